// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
package mult_arb_pkg;
    localparam int ST_W        = 2;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);
    int unsigned idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx[IDX_W-1:0]]) begin
                any    = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one shift-add multiplier among NREQ requesters.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  rsp_err,
    output logic                  mul_load,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_product,
    output logic [ST_W-1:0]       state_o
);
    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mult_arbiter: unsupported parameter set");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d;
    logic [NREQ-1:0]    gnt_q, gnt_d, valid_q, valid_d;
    logic [2*WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               load_q, load_d;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .req    (req),
        .rr_ptr (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Outputs are computed one cycle ahead and registered, so nothing reaches gnt/mul_load from req combinationally.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        valid_d = '0;
        data_d  = data_q;
        a_d     = a_q;
        b_d     = b_q;
        load_d  = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d         = ST_LOAD;
                    win_d           = pick_idx;
                    a_d             = op_a[pick_idx*WIDTH +: WIDTH];
                    b_d             = op_b[pick_idx*WIDTH +: WIDTH];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    load_d          = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (mul_done) begin
                    state_d        = ST_RESP;
                    data_d         = mul_product;
                    valid_d[win_q] = 1'b1;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d        = ST_RESP;
                    valid_d[win_q] = 1'b1;
                    err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            load_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            a_q     <= a_d;
            b_q     <= b_d;
            load_q  <= load_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign mul_load  = load_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign state_o   = state_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: job-level reference model plus directed and random stimulus.
module tb_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] op_a = '0;
    logic [NREQ*WIDTH-1:0] op_b = '0;
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_err, mul_load;
    logic [WIDTH-1:0]      mul_a, mul_b;
    logic                  mul_done = 1'b0;
    logic [2*WIDTH-1:0]    mul_product = '0;
    logic [1:0]            state_o;

    mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name, input int max);
        checks++;
        failures++;
        $display("FAIL %s actual=no-event-within-%0d-cycles required=event", name, max);
    endtask

    // Job-level reference model: phase of the current job (0 none, 1 just granted, 2 multiplying, 3 answering).
    int                 m_phase = 0;
    int                 m_ptr   = 0;
    int                 m_w     = 0;
    int                 m_wait  = 0;
    logic [NREQ-1:0]    e_gnt = '0, e_valid = '0;
    logic [2*WIDTH-1:0] e_data = '0;
    logic               e_err = 1'b0, e_load = 1'b0;
    logic [WIDTH-1:0]   e_a = '0, e_b = '0;
    logic [1:0]         e_state = 2'b00;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0; m_ptr = 0; m_w = 0; m_wait = 0;
            e_gnt = '0; e_valid = '0; e_data = '0; e_err = 1'b0; e_load = 1'b0;
            e_a = '0; e_b = '0; e_state = 2'b00;
        end else if (m_phase == 0) begin
            e_valid = '0; e_err = 1'b0;
            if (req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
                m_phase = 1;
                e_gnt   = NREQ'(1) << m_w;
                e_load  = 1'b1;
                e_a     = op_a[m_w*WIDTH +: WIDTH];
                e_b     = op_b[m_w*WIDTH +: WIDTH];
                e_state = 2'b01;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_wait = 0; e_load = 1'b0; e_state = 2'b10;
        end else if (m_phase == 2) begin
            if (mul_done) begin
                e_data = mul_product;
                m_phase = 3; e_valid = NREQ'(1) << m_w; e_state = 2'b11;
            end else begin
                m_wait++;
`ifdef MULT_ARB_TIMEOUT_EN
                if (m_wait == TIMEOUT) begin
                    m_phase = 3; e_valid = NREQ'(1) << m_w; e_state = 2'b11; e_err = 1'b1;
                end
`endif
            end
        end else begin
            m_phase = 0; e_valid = '0; e_err = 1'b0; e_gnt = '0; e_state = 2'b00;
            m_ptr = (m_w + 1) % NREQ;
        end
    end

    always @(negedge clk) begin
        check("cyc_gnt", gnt, e_gnt);
        check("cyc_rsp_valid", rsp_valid, e_valid);
        check("cyc_rsp_data", rsp_data, e_data);
        check("cyc_rsp_err", rsp_err, e_err);
        check("cyc_mul_load", mul_load, e_load);
        check("cyc_mul_a", mul_a, e_a);
        check("cyc_mul_b", mul_b, e_b);
        check("cyc_state", state_o, e_state);
    end

    // Multiplier stand-in: fixed or random latency after each load, plus optional stray pulses.
    bit                 mul_auto = 1'b1, mul_rand = 1'b0, spur_en = 1'b0, manual_pulse = 1'b0;
    int                 mul_lat = 9;
    int                 cd = 0;
    logic [2*WIDTH-1:0] prod_pending = '0, manual_prod = '0;

    always @(negedge clk) begin
        mul_done = 1'b0;
        if (!rst) cd = 0;
        if (manual_pulse) begin
            mul_done = 1'b1; mul_product = manual_prod; manual_pulse = 1'b0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin mul_done = 1'b1; mul_product = prod_pending; end
        end else if (spur_en && m_phase != 2 && $urandom_range(0, 7) == 0) begin
            mul_done = 1'b1; mul_product = 16'($urandom);
        end
        if (mul_auto && mul_load && rst) begin
            cd = mul_rand ? int'($urandom_range(1, 12)) : mul_lat;
            prod_pending = 16'(e_a) * 16'(e_b);
        end
    end

    function automatic int oh2idx(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic run_until_rsp(input string name, input int max,
                                 output logic [NREQ-1:0] g, output logic [NREQ-1:0] v,
                                 output logic [2*WIDTH-1:0] d, output int loads, output int lat);
        int n = 0;
        int lc = 0;
        bit got = 1'b0;
        g = '0; v = '0; d = '0; loads = 0; lat = -1;
        while (!got && n < max) begin
            @(negedge clk);
            n++;
            if (mul_load) begin loads++; g = gnt; lc = n; end
            if (|rsp_valid) begin v = rsp_valid; d = rsp_data; lat = n - lc; got = 1'b1; end
        end
        if (!got) fail_bound(name, max);
    endtask

    task automatic wait_state(input string name, input logic [1:0] s, input int max);
        int n = 0;
        while (state_o !== s && n < max) begin @(negedge clk); n++; end
        if (state_o !== s) fail_bound(name, max);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        op_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        op_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    logic [NREQ-1:0]    g, v;
    logic [2*WIDTH-1:0] d, last_data;
    int                 loads, lat;
    bit                 active [NREQ];

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {gnt, rsp_valid, rsp_data, rsp_err, mul_load, mul_a, mul_b, state_o}, 64'd0);
        rst = 1'b1;

        // Single job on requester 1
        set_ops(1, 13, 11); req = 4'b0010; mul_lat = 9;
        run_until_rsp("single_rsp", 40, g, v, d, loads, lat);
        req = '0;
        check("single_gnt", g, 4'b0010);
        check("single_loads", loads, 1);
        check("single_valid", v, 4'b0010);
        check("single_data", d, 143);
        check("single_latency", lat, 10);

        // Boundary operands
        @(negedge clk);
        set_ops(2, 255, 255); req = 4'b0100; mul_lat = 3;
        run_until_rsp("max_rsp", 40, g, v, d, loads, lat);
        req = '0;
        check("max_valid", v, 4'b0100);
        check("max_data", d, 65025);
        @(negedge clk);
        set_ops(0, 0, 200); req = 4'b0001; mul_lat = 1;
        run_until_rsp("zero_rsp", 40, g, v, d, loads, lat);
        req = '0;
        check("zero_valid", v, 4'b0001);
        check("zero_data", d, 0);

        // Fairness from a fresh pointer with all requesters held
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 3 + i);
        req = 4'b1111; mul_lat = 2;
        for (int j = 0; j < 5; j++) begin
            run_until_rsp($sformatf("fair_rsp%0d", j), 40, g, v, d, loads, lat);
            check($sformatf("fair_grant%0d", j), oh2idx(g), j % NREQ);
        end
        req = '0;
        last_data = d;

        // Stray completion in IDLE, then requester drops req during WAIT
        manual_prod = 16'hBEEF; manual_pulse = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stale_no_valid", rsp_valid, 0);
            check("stale_idle", state_o, 2'b00);
        end
        check("stale_data_kept", rsp_data, last_data);
        set_ops(3, 7, 9); req = 4'b1000; mul_lat = 6;
        wait_state("drop_wait", 2'b10, 20);
        req = '0;
        run_until_rsp("drop_rsp", 40, g, v, d, loads, lat);
        check("drop_valid", v, 4'b1000);
        check("drop_data", d, 63);

        // Reset while the multiplier is busy
        @(negedge clk);
        mul_auto = 1'b0; set_ops(2, 5, 5); req = 4'b0100;
        wait_state("rstwait_wait", 2'b10, 20);
        rst = 1'b0; req = '0;
        @(negedge clk); rst = 1'b1;
        manual_prod = 16'h1234; manual_pulse = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstwait_no_valid", rsp_valid, 0);
        end
        check("rstwait_outputs", {gnt, rsp_valid, rsp_data, rsp_err, mul_load, mul_a, mul_b, state_o}, 64'd0);

        // Multiplier never answers
        req = 4'b0001;
`ifdef MULT_ARB_TIMEOUT_EN
        run_until_rsp("timeout_rsp", 100, g, v, d, loads, lat);
        check("timeout_err", rsp_err, 1'b1);
        check("timeout_valid", v, 4'b0001);
        check("timeout_data_kept", d, 0);
        check("timeout_latency", lat, TIMEOUT + 1);
        req = '0;
`else
        wait_state("hang_wait", 2'b10, 20);
        repeat (100) @(negedge clk);
        check("hang_state", state_o, 2'b10);
        check("hang_no_valid", rsp_valid, 0);
        req = '0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
`endif

        // Random traffic
        mul_auto = 1'b1; mul_rand = 1'b1; spur_en = 1'b1;
        for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    active[i] = 1'b0; req[i] = 1'b0;
                end else if (!active[i] && $urandom_range(0, 3) == 0) begin
                    active[i] = 1'b1; req[i] = 1'b1;
                    set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                end
            end
            if (m_phase == 2 && req[m_w] && $urandom_range(0, 15) == 0) req[m_w] = 1'b0;
        end
        begin
            int n = 0;
            while ((active[0] || active[1] || active[2] || active[3] || m_phase != 0) && n < 300) begin
                @(negedge clk); n++;
                for (int i = 0; i < NREQ; i++)
                    if (rsp_valid[i]) begin active[i] = 1'b0; req[i] = 1'b0; end
            end
            if (n >= 300) fail_bound("drain", 300);
        end
        spur_en = 1'b0;
        repeat (2) @(negedge clk);
        check("drain_idle", state_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one shift-add multiplier (sequencer plus datapath) among `NREQ` requesters. It latches the winning requester's operands and issues a one-cycle load to the multiplier. It then waits for the multiplier's completion pulse and returns the product to the winning requester with a one-cycle response strobe. It sits between the client blocks and the multiplier sequencer's load/ready handshake.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand width; product is `2*WIDTH`.
- `TIMEOUT`, default 64: watchdog limit in cycles; used only with the macro.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `req`, input, `NREQ`: per-requester request level; must be held until that requester's `rsp_valid`.
- `op_a`, input, `NREQ*WIDTH`: multiplicands; slice i belongs to requester i.
- `op_b`, input, `NREQ*WIDTH`: multipliers; slice i belongs to requester i.
- `gnt`, output, `NREQ`: one-hot grant, held from LOAD through RESP.
- `rsp_valid`, output, `NREQ`: one-cycle completion strobe to the granted requester.
- `rsp_data`, output, `2*WIDTH`: product; holds its value until the next RESP.
- `rsp_err`, output, 1: qualifies `rsp_valid` as a timeout; tied 0 without the macro.
- `mul_load`, output, 1: one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`, output, `WIDTH`: latched operands, stable from LOAD until leaving WAIT.
- `mul_done`, input, 1: multiplier ready pulse; sampled only in WAIT.
- `mul_product`, input, `2*WIDTH`: valid in the cycle `mul_done` is high.
- `state_o`, output, 2: current state encoding, for debug.

## Operation
- State encodings: IDLE=00, LOAD=01, WAIT=10, RESP=11.
- IDLE:
  - If any `req` bit is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `NREQ`.
  - Latch the winner's index and its `op_a`/`op_b` slices; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `mul_load`=1 and `gnt`=onehot(winner); next state is WAIT unconditionally.
- WAIT:
  - On `mul_done`=1, latch `mul_product` into `rsp_data` and go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - `rsp_valid[winner]`=1 for exactly one cycle.
  - `rr_ptr` ← (winner+1) mod `NREQ`.
  - Next state is IDLE.
- Multiplication: `rsp_data` = `mul_product` unmodified. The block performs no arithmetic other than the pointer wrap.
- Requester drops `req` during LOAD/WAIT: the operation still completes and RESP is still issued. Abandonment is not supported.
- `mul_done` seen in IDLE, LOAD or RESP (stale or spurious) is ignored.
- Only one requester active: it is granted every round, regardless of `rr_ptr`.
- `rr_ptr` wraps: with `NREQ`=4 and winner 3, `rr_ptr` becomes 0.

## Timing
- Reset values (while `rst`=0 at a clock edge): state IDLE, `rr_ptr`=0, and every output is 0 (`gnt`, `rsp_valid`, `rsp_data`, `rsp_err`, `mul_load`, `mul_a`, `mul_b`, `state_o`).
- Reset mid-operation aborts immediately. No response is issued, and a later `mul_done` is dropped because the block is in IDLE.
- Latency:
  - `req` high at edge t (in IDLE) → LOAD in cycle t+1.
  - `mul_done` at edge d → `rsp_valid` in cycle d+1.
  - IDLE is re-entered at d+2.
- Turnaround: 3 overhead cycles per job (IDLE, LOAD, RESP) plus the multiplier latency. There are no back-to-back grants without passing through IDLE.
- `gnt` and `mul_load` are registered outputs, with no combinational path from `req`.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A counter runs while in WAIT.
  - If `TIMEOUT` cycles elapse without `mul_done`, go to RESP with `rsp_err`=1 and `rsp_data` unchanged.
  - `rsp_err` is 0 for normal completions.
  - The counter clears on entering WAIT.
- Macro undefined: no counter is built, `rsp_err` is constant 0, and WAIT waits indefinitely.

## Structure
- `mult_arb_pkg` holds:
  - the `arb_state_t` enum with the encodings above;
  - the `ST_W`=2 constant;
  - the default width constants.
- One sub-module, `rr_picker`: combinational round-robin first-set-bit search over `req` starting at `rr_ptr`. It outputs `any` and the winner index.

## Test plan
- Single job, `NREQ`=4, `WIDTH`=8: `req`=0010 with `op_a[1]`=13 and `op_b[1]`=11; model `mul_done` 9 cycles after `mul_load` with product 143 → `gnt`=0010, one `mul_load`, `rsp_valid`=0010 with `rsp_data`=143.
- Fairness: `req`=1111 held and refilled after each response → grants in order 0,1,2,3,0, with `rr_ptr` wrapping 3→0.
- Boundary operands: 255×255 → 65025; 0×200 → 0; both delivered to the correct requester.
- Reset in WAIT: drop `rst` for 1 cycle, then pulse `mul_done` → no `rsp_valid`, `state_o`=00, all outputs 0.
- Timeout (macro defined, `TIMEOUT`=64): never pulse `mul_done` → at WAIT cycle 64, `rsp_valid` and `rsp_err`=1 with `rsp_data` unchanged. Without the macro, the block stays in WAIT.
- Stale `mul_done` in IDLE, and `req` dropped during WAIT → stale pulse ignored; the dropped requester still gets `rsp_valid`.
